// File: rtl/interrupt_pending_latch.sv
// interrupt_pending_latch
//
// Front end of the interrupt path. It sits ahead of the 16-input priority encoder.
// The 16 raw request lines are synchronised and, for edge-type lines, latched until
// the CPU acknowledges them. A software mask is then applied. The acknowledge index
// returned by the CPU is decoded back into a one-hot clear of the matching pending bit.
//
// Parameters
//   SYNC_STAGES  synchronizer flops per irq line (2 or more)
//   EDGE_MASK    per-line type: 1 = edge-triggered/latched, 0 = level-sensitive
//
// Ports
//   clk              system clock, all state on the rising edge
//   resetN           asynchronous active-low reset
//   irqLines[15:0]   raw asynchronous interrupt request lines
//   ackValid         one-cycle strobe: CPU acknowledges interrupt ackIndex
//   ackIndex[3:0]    index being acknowledged (encoder output fed back)
//   maskWriteEnable  load the mask register this cycle
//   maskWriteData    new mask value, 1 enables a line
//   mask             current mask register
//   pendingSignals   rawPending & mask, feeds the priority encoder
//   anyPending       OR of pendingSignals
//   ackError         one-cycle pulse: acknowledge hit a line that was not pending

module interrupt_pending_latch #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] EDGE_MASK   = 16'h0000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [15:0] irqLines,
    input  logic        ackValid,
    input  logic [3:0]  ackIndex,
    input  logic        maskWriteEnable,
    input  logic [15:0] maskWriteData,
    output logic [15:0] mask,
    output logic [15:0] pendingSignals,
    output logic        anyPending,
    output logic        ackError
);

    // Synchronizer chains, stored stage-major: syncStageReg[s][i] is stage s of line i.
    logic [15:0] syncStageReg [SYNC_STAGES];
    logic [15:0] syncLine;

    logic [15:0] prevLineReg;
    logic [15:0] rawPendingReg;
    logic [15:0] rawPendingNext;
    logic [15:0] maskReg;
    logic        ackErrorReg;
    logic        ackErrorNext;

    logic [15:0] ackDecode;
    logic [15:0] ackClear;
    logic [15:0] edgeSeen;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                syncStageReg[s] <= '0;
            end
        end else begin
            syncStageReg[0] <= irqLines;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                syncStageReg[s] <= syncStageReg[s-1];
            end
        end
    end

    assign syncLine = syncStageReg[SYNC_STAGES-1];

    // One-hot decode of the acknowledged index. This is all zero when no ack is presented.
    always_comb begin
        ackDecode = '0;
        if (ackValid) begin
            ackDecode = 16'h0001 << ackIndex;
        end
    end

    // Only a genuine acknowledge clears anything. The ack must hit a bit that is
    // visible on pendingSignals, so an erroneous ack leaves state untouched.
    // Level lines ignore the clear entirely.
    assign ackClear = ackDecode & pendingSignals & EDGE_MASK;

    // prevLineReg resets to 0, so a line already high at reset release counts as an edge.
    assign edgeSeen = syncLine & ~prevLineReg;

    // Edge lines: a new edge sets the bit even when a clear lands in the same cycle,
    // so a fresh request is never lost. Level lines simply follow the synced input.
    assign rawPendingNext = (EDGE_MASK & (edgeSeen | (rawPendingReg & ~ackClear)))
                          | (~EDGE_MASK & syncLine);

    // This check uses the mask as it stands during the ack cycle. A mask write in the
    // same cycle therefore has no influence on it.
    assign ackErrorNext = ackValid & ~pendingSignals[ackIndex];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prevLineReg   <= '0;
            rawPendingReg <= '0;
            maskReg       <= '0;
            ackErrorReg   <= 1'b0;
        end else begin
            prevLineReg   <= syncLine;
            rawPendingReg <= rawPendingNext;
            ackErrorReg   <= ackErrorNext;
            if (maskWriteEnable) begin
                maskReg <= maskWriteData;
            end
        end
    end

    // Built only from registers, so the encoder inputs are glitch-free.
    assign pendingSignals = rawPendingReg & maskReg;
    assign anyPending     = |pendingSignals;
    assign mask           = maskReg;
    assign ackError       = ackErrorReg;

endmodule

// File: tb/tb_interrupt_pending_latch.sv
// Scoreboard bench for interrupt_pending_latch.
// Line 9 is level-sensitive and every other line is edge-type.
// Stimulus is applied 1 time unit after a falling edge. Each expectation is pushed
// with the clock-edge count after which it must hold. A monitor pops the
// expectation and compares it on the following falling edge.

module tb_interrupt_pending_latch;

    localparam logic [15:0] EDGE_CFG = 16'hFDFF;

    logic        clk = 1'b0;
    logic        resetN;
    logic [15:0] irqLines;
    logic        ackValid;
    logic [3:0]  ackIndex;
    logic        maskWriteEnable;
    logic [15:0] maskWriteData;
    logic [15:0] mask;
    logic [15:0] pendingSignals;
    logic        anyPending;
    logic        ackError;

    int cyc = 0;
    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        int          due;
        string       tag;
        logic [15:0] mask;
        logic [15:0] pend;
        logic        ackErr;
    } expEntry;

    expEntry sbQueue[$];
    expEntry monEntry;

    interrupt_pending_latch #(
        .SYNC_STAGES(2),
        .EDGE_MASK  (EDGE_CFG)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .irqLines       (irqLines),
        .ackValid       (ackValid),
        .ackIndex       (ackIndex),
        .maskWriteEnable(maskWriteEnable),
        .maskWriteData  (maskWriteData),
        .mask           (mask),
        .pendingSignals (pendingSignals),
        .anyPending     (anyPending),
        .ackError       (ackError)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expectAt(input int due, input string tag, input logic [15:0] m,
                            input logic [15:0] p, input logic e);
        expEntry ent;
        ent.due    = due;
        ent.tag    = tag;
        ent.mask   = m;
        ent.pend   = p;
        ent.ackErr = e;
        sbQueue.push_back(ent);
    endtask

    // Waits for the falling edge at which the edge count reaches t, then moves 1 unit past it.
    task automatic atCycle(input int t);
        while (cyc < t) @(negedge clk);
        #1;
    endtask

    // Monitor: compare every expectation that falls due at this falling edge.
    always @(negedge clk) begin
        while (sbQueue.size() > 0 && sbQueue[0].due <= cyc) begin
            monEntry = sbQueue.pop_front();
            if (monEntry.due < cyc) begin
                checkValue({monEntry.tag, "_late"}, cyc, monEntry.due);
            end else begin
                checkValue({monEntry.tag, "_mask"}, mask, monEntry.mask);
                checkValue({monEntry.tag, "_pend"}, pendingSignals, monEntry.pend);
                checkValue({monEntry.tag, "_any"}, anyPending, |monEntry.pend);
                checkValue({monEntry.tag, "_ackErr"}, ackError, monEntry.ackErr);
                $display("txn cyc=%0d %s mask=%h pend=%h any=%b ackErr=%b",
                         cyc, monEntry.tag, mask, pendingSignals, anyPending, ackError);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        resetN          = 1'b0;
        irqLines        = 16'hFFFF;
        ackValid        = 1'b0;
        ackIndex        = 4'd0;
        maskWriteEnable = 1'b0;
        maskWriteData   = 16'h0000;

        // Reset held with all lines high.
        repeat (3) begin
            @(negedge clk);
            checkValue("rst_mask", mask, 16'h0000);
            checkValue("rst_pend", pendingSignals, 16'h0000);
            checkValue("rst_any", anyPending, 1'b0);
            checkValue("rst_ackErr", ackError, 1'b0);
        end
        #1 irqLines = 16'h0000;
        @(negedge clk);
        #1 resetN = 1'b1;
        t = cyc;

        // Enable all lines.
        maskWriteEnable = 1'b1; maskWriteData = 16'hFFFF;
        expectAt(t+1, "maskAll", 16'hFFFF, 16'h0000, 1'b0);
        atCycle(t+1); maskWriteEnable = 1'b0;

        // Edge latch on line 5: a one-cycle pulse, then it is visible two edges after capture.
        atCycle(t+2); irqLines = 16'h0020;
        expectAt(t+4, "edge5_early", 16'hFFFF, 16'h0000, 1'b0);
        expectAt(t+5, "edge5_set",   16'hFFFF, 16'h0020, 1'b0);
        expectAt(t+7, "edge5_hold",  16'hFFFF, 16'h0020, 1'b0);
        atCycle(t+3); irqLines = 16'h0000;
        atCycle(t+8); ackValid = 1'b1; ackIndex = 4'd5;
        expectAt(t+9, "ack5", 16'hFFFF, 16'h0000, 1'b0);
        atCycle(t+9); ackValid = 1'b0;

        // Set-wins race on line 3.
        atCycle(t+10); irqLines = 16'h0008;
        expectAt(t+13, "edge3_set", 16'hFFFF, 16'h0008, 1'b0);
        atCycle(t+11); irqLines = 16'h0000;
        atCycle(t+15); irqLines = 16'h0008;   // synced rising edge lands at edge t+18
        atCycle(t+16); irqLines = 16'h0000;
        atCycle(t+17); ackValid = 1'b1; ackIndex = 4'd3;
        expectAt(t+18, "race3",      16'hFFFF, 16'h0008, 1'b0);
        expectAt(t+19, "race3_hold", 16'hFFFF, 16'h0008, 1'b0);
        atCycle(t+18); ackValid = 1'b0;
        atCycle(t+21); ackValid = 1'b1; ackIndex = 4'd3;
        expectAt(t+22, "ack3", 16'hFFFF, 16'h0000, 1'b0);
        atCycle(t+22); ackValid = 1'b0;

        // Level line 9: it follows the input and ignores acknowledges.
        atCycle(t+24); irqLines = 16'h0200;
        expectAt(t+26, "lvl9_early", 16'hFFFF, 16'h0000, 1'b0);
        expectAt(t+27, "lvl9_set",   16'hFFFF, 16'h0200, 1'b0);
        atCycle(t+28); ackValid = 1'b1; ackIndex = 4'd9;
        expectAt(t+29, "lvl9_ack",  16'hFFFF, 16'h0200, 1'b0);
        expectAt(t+30, "lvl9_hold", 16'hFFFF, 16'h0200, 1'b0);
        atCycle(t+29); ackValid = 1'b0;
        atCycle(t+31); irqLines = 16'h0000;
        expectAt(t+33, "lvl9_dropLate", 16'hFFFF, 16'h0200, 1'b0);
        expectAt(t+34, "lvl9_drop",     16'hFFFF, 16'h0000, 1'b0);

        // Masking: line 12 latches while masked and appears once it is unmasked.
        atCycle(t+36); maskWriteEnable = 1'b1; maskWriteData = 16'h0000;
        expectAt(t+37, "mask0", 16'h0000, 16'h0000, 1'b0);
        atCycle(t+37); maskWriteEnable = 1'b0;
        atCycle(t+38); irqLines = 16'h1000;
        expectAt(t+41, "m12_hidden",  16'h0000, 16'h0000, 1'b0);
        expectAt(t+42, "m12_hidden2", 16'h0000, 16'h0000, 1'b0);
        atCycle(t+39); irqLines = 16'h0000;
        atCycle(t+43); maskWriteEnable = 1'b1; maskWriteData = 16'h1000;
        expectAt(t+44, "m12_unmask", 16'h1000, 16'h1000, 1'b0);
        atCycle(t+44); maskWriteEnable = 1'b0;
        atCycle(t+46); ackValid = 1'b1; ackIndex = 4'd12;
        expectAt(t+47, "ack12", 16'h1000, 16'h0000, 1'b0);
        atCycle(t+47); ackValid = 1'b0;
        atCycle(t+48); maskWriteEnable = 1'b1; maskWriteData = 16'hFFFF;
        expectAt(t+49, "maskAll2", 16'hFFFF, 16'h0000, 1'b0);
        atCycle(t+49); maskWriteEnable = 1'b0;

        // Spurious ack of line 4 while only line 0 is pending.
        atCycle(t+50); irqLines = 16'h0001;
        expectAt(t+53, "edge0_set", 16'hFFFF, 16'h0001, 1'b0);
        atCycle(t+51); irqLines = 16'h0000;
        atCycle(t+54); ackValid = 1'b1; ackIndex = 4'd4;
        expectAt(t+55, "spur4",      16'hFFFF, 16'h0001, 1'b1);
        expectAt(t+56, "spur4_next", 16'hFFFF, 16'h0001, 1'b0);
        atCycle(t+55); ackValid = 1'b0;

        // Ack and mask write in the same cycle: the check uses the old mask, so this ack is valid.
        atCycle(t+57);
        maskWriteEnable = 1'b1; maskWriteData = 16'hFFFE;
        ackValid = 1'b1; ackIndex = 4'd0;
        expectAt(t+58, "ackMask0", 16'hFFFE, 16'h0000, 1'b0);
        atCycle(t+58); maskWriteEnable = 1'b0; ackValid = 1'b0;

        // Async reset mid-cycle discards a pending line 2.
        atCycle(t+60); irqLines = 16'h0004;
        expectAt(t+63, "edge2_set", 16'hFFFE, 16'h0004, 1'b0);
        atCycle(t+65);
        #1 resetN = 1'b0;
        #1;
        checkValue("arst_mask", mask, 16'h0000);
        checkValue("arst_pend", pendingSignals, 16'h0000);
        checkValue("arst_any", anyPending, 1'b0);
        checkValue("arst_ackErr", ackError, 1'b0);

        // Release the reset with line 2 still high: this must register as a fresh edge.
        atCycle(t+67);
        resetN = 1'b1;
        maskWriteEnable = 1'b1; maskWriteData = 16'hFFFF;
        expectAt(t+68, "rel_mask",  16'hFFFF, 16'h0000, 1'b0);
        expectAt(t+69, "rel_early", 16'hFFFF, 16'h0000, 1'b0);
        expectAt(t+70, "rel_edge2", 16'hFFFF, 16'h0004, 1'b0);
        atCycle(t+68); maskWriteEnable = 1'b0;

        for (int i = 0; i < 20 && sbQueue.size() > 0; i++) @(negedge clk);
        checkValue("sb_drain", sbQueue.size(), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
